// File: rtl/nor3_cell_exerciser_if.sv
// Drive/check bundle between the nor3 cell exerciser and its surroundings.
// master = exerciser side, slave = cell-under-test / wrapper side.
interface nor3_cell_exerciser_if;
  logic       START;
  logic       ZN;
  logic       A1;
  logic       A2;
  logic       A3;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [7:0] ERR_CNT;
  logic       FAIL_VALID;
  logic [2:0] FAIL_VEC;

  modport master (
    input  START, ZN,
    output A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );

  modport slave (
    output START, ZN,
    input  A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC
  );
endinterface

// File: rtl/nor3_cell_exerciser.sv
// Sweeps all eight {A3,A2,A1} vectors into a 3-input NOR cell, samples ZN after a
// programmable settle time and reports pass/fail, error count and first failing vector.
module nor3_cell_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input logic                  CLK,
  input logic                  RST,
  nor3_cell_exerciser_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] settle_q, settle_d;
  logic [3:0] pass_cnt_q, pass_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic       fail_valid_q, fail_valid_d;
  logic [2:0] fail_vec_q, fail_vec_d;
  logic       expected;
  logic       mismatch;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      pass_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      pass_cnt_q   <= pass_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    pass_cnt_d   = pass_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    expected     = (vec_q == 3'd0);
    mismatch     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d      = RUN;
          busy_d       = 1'b1;
          vec_d        = '0;
          settle_d     = '0;
          pass_cnt_d   = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
        end
      end

      RUN: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SETTLE_LAST) begin
          // X/Z on ZN must count as a mismatch, hence case-inequality
          mismatch = (bus.ZN !== expected);
          settle_d = '0;
          vec_d    = vec_q + 3'd1;
          if (mismatch) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end
          if (vec_q == 3'd7) begin
            pass_cnt_d = pass_cnt_q + 4'd1;
            if (pass_cnt_q == PASS_LAST) begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_d == 8'd0);
            end
          end
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // vec is zero outside RUN (reset, START and the final 7->0 wrap), so it can drive the pins directly
  assign bus.A1         = vec_q[0];
  assign bus.A2         = vec_q[1];
  assign bus.A3         = vec_q[2];
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
  assign bus.ERR_CNT    = err_q;
  assign bus.FAIL_VALID = fail_valid_q;
  assign bus.FAIL_VEC   = fail_vec_q;

endmodule
